// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: turns EX/MEM control bits into valid/ready bus transactions,
// stalls the pipeline while an access is in flight. Optional misalignment trap: MISALIGN_TRAP_EN.
module mem_stage_dmem_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int RSP_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_write_m,
   input  logic              mem_write_m,
   input  logic [1:0]        result_src_m,
   input  logic [2:0]        funct3_m,
   input  logic [31:0]       alu_result_m,
   input  logic [31:0]       write_data_m,
   output logic              stall_m,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_req_we,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic [31:0]       dmem_req_wdata,
   output logic [3:0]        dmem_req_be,
   input  logic              dmem_rsp_valid,
   input  logic [31:0]       dmem_rsp_rdata,
   output logic [31:0]       read_data_m,
   output logic              reg_write_w_o,
   output logic              bus_err
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misalign_o
`endif
);

   localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic [1:0]          off_q, off_d;
   logic [2:0]          f3_q, f3_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                mis_q, mis_d;

   logic                access;
   logic [1:0]          off;
   logic [3:0]          beNew;
   logic [31:0]         wdataNew;
   logic [1:0]          offNew;
   logic [31:0]         shifted;
   logic [31:0]         extData;
   logic                timeoutHit;

   assign access = mem_write_m | (result_src_m == 2'b01);
   assign off    = alu_result_m[1:0];

   // Lane placement: halves keep only addr[1], words ignore the low address bits.
   always_comb begin
      beNew    = 4'b1111;
      wdataNew = write_data_m;
      offNew   = 2'b00;
      case (funct3_m[1:0])
         2'b00: begin
            beNew    = 4'b0001 << off;
            wdataNew = {4{write_data_m[7:0]}};
            offNew   = off;
         end
         2'b01: begin
            beNew    = 4'b0011 << {off[1], 1'b0};
            wdataNew = {2{write_data_m[15:0]}};
            offNew   = {off[1], 1'b0};
         end
         default: begin
            beNew    = 4'b1111;
            wdataNew = write_data_m;
            offNew   = 2'b00;
         end
      endcase
   end

   always_comb begin
      shifted = dmem_rsp_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  extData = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  extData = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  extData = {24'h000000, shifted[7:0]};
         3'b101:  extData = {16'h0000, shifted[15:0]};
         default: extData = shifted;
      endcase
   end

   assign timeoutHit = (RSP_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(RSP_TIMEOUT));

`ifdef MISALIGN_TRAP_EN
   logic misal;
   always_comb begin
      case (funct3_m[1:0])
         2'b00:   misal = 1'b0;
         2'b01:   misal = off[0];
         default: misal = |off;
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      off_d   = off_q;
      f3_d    = f3_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      stall_m = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               stall_m = 1'b1;
               we_d    = mem_write_m;
               addr_d  = {alu_result_m[ADDR_W-1:2], 2'b00};
               wdata_d = wdataNew;
               be_d    = beNew;
               off_d   = offNew;
               f3_d    = funct3_m;
               state_d = REQ;
`ifdef MISALIGN_TRAP_EN
               if (misal) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  mis_d   = 1'b1;
                  rdata_d = 32'h0;
               end
`endif
            end
         end
         REQ: begin
            stall_m = 1'b1;
            if (dmem_req_ready) begin
               cnt_d   = '0;
               state_d = we_q ? DONE : WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            stall_m = 1'b1;
            if (dmem_rsp_valid) begin
               rdata_d = extData;
               state_d = DONE;
            end else if (RSP_TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (timeoutHit) begin
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset also kills an in-flight request; a late response then lands in IDLE and is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         off_q   <= 2'b00;
         f3_q    <= 3'b000;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   // err_q is only ever set on entry to DONE, so it doubles as the one-cycle bus_err pulse.
   assign dmem_req_valid = (state_q == REQ);
   assign dmem_req_we    = we_q;
   assign dmem_req_addr  = addr_q;
   assign dmem_req_wdata = wdata_q;
   assign dmem_req_be    = be_q;
   assign read_data_m    = rdata_q;
   assign reg_write_w_o  = reg_write_m & ~err_q;
   assign bus_err        = err_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_o     = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Scoreboard bench for mem_stage_dmem_ctrl: a reference model predicts bus requests and completions,
// a monitor compares them as the DUT presents them. Set MISALIGN_TRAP_EN to exercise the trap.
`timescale 1ns/1ps
module tb_mem_stage_dmem_ctrl;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reg_write_m = 1'b0;
   logic        mem_write_m = 1'b0;
   logic [1:0]  result_src_m = 2'b00;
   logic [2:0]  funct3_m = 3'b000;
   logic [31:0] alu_result_m = 32'h0;
   logic [31:0] write_data_m = 32'h0;
   logic        stall_m;
   logic        dmem_req_valid;
   logic        dmem_req_ready = 1'b0;
   logic        dmem_req_we;
   logic [31:0] dmem_req_addr;
   logic [31:0] dmem_req_wdata;
   logic [3:0]  dmem_req_be;
   logic        dmem_rsp_valid = 1'b0;
   logic [31:0] dmem_rsp_rdata = 32'h0;
   logic [31:0] read_data_m;
   logic        reg_write_w_o;
   logic        bus_err;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   mem_stage_dmem_ctrl #(.ADDR_W(32), .RSP_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
      .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
      .stall_m(stall_m), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
      .dmem_req_be(dmem_req_be), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .read_data_m(read_data_m), .reg_write_w_o(reg_write_w_o), .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
      , .misalign_o(misalign_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } reqT;

   typedef struct {
      int          stall;
      logic [31:0] rd;
      bit          rw;
      bit          err;
      bit          mis;
   } doneT;

   reqT         reqQ[$];
   doneT        doneQ[$];
   int          checks = 0;
   int          failures = 0;
   bit          monEnable = 1'b0;
   int          monStall = 0;
   logic [31:0] modelRd = 32'h0;
   logic [2:0]  loadF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Monitor: samples late in the low phase, compares against the predicted queues.
   initial begin : monitor
      reqT  r;
      doneT d;
      forever begin
         @(negedge clk);
         #3;
         if (!monEnable) begin
            monStall = 0;
         end else begin
            if (dmem_req_valid) begin
               if (reqQ.size() == 0) begin
                  checkOutput("req_unexpected", {31'b0, dmem_req_valid}, 32'd0);
               end else begin
                  r = reqQ[0];
                  checkOutput("req_we", {31'b0, dmem_req_we}, {31'b0, r.we});
                  checkOutput("req_addr", dmem_req_addr, r.addr);
                  checkOutput("req_be", {28'b0, dmem_req_be}, {28'b0, r.be});
                  if (r.we) checkOutput("req_wdata", dmem_req_wdata, r.wdata);
                  if (dmem_req_ready) void'(reqQ.pop_front());
               end
            end
            if (stall_m) begin
               monStall++;
            end else if (monStall > 0) begin
               if (doneQ.size() == 0) begin
                  checkOutput("done_unexpected", 32'(monStall), 32'd0);
               end else begin
                  d = doneQ.pop_front();
                  checkOutput("stall_cycles", 32'(monStall), 32'(d.stall));
                  checkOutput("read_data", read_data_m, d.rd);
                  checkOutput("bus_err", {31'b0, bus_err}, {31'b0, d.err});
                  checkOutput("reg_write_w", {31'b0, reg_write_w_o}, {31'b0, d.rw});
`ifdef MISALIGN_TRAP_EN
                  checkOutput("misalign", {31'b0, misalign_o}, {31'b0, d.mis});
`endif
               end
               monStall = 0;
            end else begin
               checkOutput("bus_err_idle", {31'b0, bus_err}, 32'd0);
            end
         end
      end
   end

   // Predicts the transaction from size/offset arithmetic, then plays both pipeline and memory.
   task automatic applyStimulus(input bit st, input bit ld, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input int readyDly,
                                input int rspDly, input bit rw);
      int          sz, off, n;
      bit          isStore, misal, tmo;
      logic [31:0] mask, v;
      reqT         r;
      doneT        d;
      isStore = st;
      sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off = (sz == 1) ? int'(addr % 4) : (sz == 2) ? int'((addr % 4) / 2 * 2) : 0;
      misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misal = (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
`endif
      tmo = !isStore && !misal && (rspDly < 0 || rspDly >= TIMEOUT);
      r.we    = isStore;
      r.addr  = addr - (addr % 4);
      r.be    = 4'(((1 << sz) - 1) << off);
      r.wdata = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v = (rdata >> (8 * off)) & mask;
      if (!f3[2] && sz < 4 && v >= (mask + 32'd1) / 2) v = v | ~mask;
      if (misal || tmo) modelRd = 32'h0;
      else if (!isStore) modelRd = v;
      d.stall = misal ? 1 : 2 + readyDly + (isStore ? 0 : (tmo ? TIMEOUT : rspDly + 1));
      d.rd  = modelRd;
      d.rw  = rw && !(misal || tmo);
      d.err = misal || tmo;
      d.mis = misal;
      if (!misal) reqQ.push_back(r);
      doneQ.push_back(d);

      @(negedge clk);
      mem_write_m    = st;
      result_src_m   = ld ? 2'b01 : 2'b00;
      funct3_m       = f3;
      alu_result_m   = addr;
      write_data_m   = wd;
      reg_write_m    = rw;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      #1;
      if (!misal) begin
         n = 0;
         @(negedge clk);
         while (!dmem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!dmem_req_valid) checkOutput("req_valid_wait", {31'b0, dmem_req_valid}, 32'd1);
         repeat (readyDly) @(negedge clk);
         dmem_req_ready = 1'b1;
         @(negedge clk);
         dmem_req_ready = 1'b0;
         if (!isStore && !tmo) begin
            repeat (rspDly) @(negedge clk);
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = rdata;
            @(negedge clk);
            dmem_rsp_valid = 1'b0;
            dmem_rsp_rdata = $urandom;
         end
      end
      n = 0;
      while (stall_m && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (stall_m) checkOutput("done_wait", {31'b0, stall_m}, 32'd0);
      @(negedge clk);
      mem_write_m  = 1'b0;
      result_src_m = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      reg_write_m  = 1'($urandom_range(0, 1));
      alu_result_m = $urandom;
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bit          st, ld;
      logic [2:0]  f3;
      int          rsp;
      #2;
      checkOutput("rst_stall", {31'b0, stall_m}, 32'd0);
      checkOutput("rst_valid", {31'b0, dmem_req_valid}, 32'd0);
      checkOutput("rst_read_data", read_data_m, 32'd0);
      checkOutput("rst_bus_err", {31'b0, bus_err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      monEnable = 1'b1;
      @(negedge clk);

      applyStimulus(1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, 1'b1);
      applyStimulus(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b1);
      applyStimulus(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1'b1);
      applyStimulus(1'b1, 1'b0, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 4, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1, -1, 1'b1);
      applyStimulus(1'b1, 1'b1, 3'b000, 32'h31, 32'h000000A5, 32'h0, 0, 0, 1'b0);

      // Reset mid-request; EX/MEM is reset alongside, so MEM inputs clear with it.
      monEnable = 1'b0;
      @(negedge clk);
      mem_write_m  = 1'b0;
      result_src_m = 2'b01;
      funct3_m     = 3'b010;
      alu_result_m = 32'h200;
      reg_write_m  = 1'b1;
      @(negedge clk);
      #2;
      checkOutput("pre_rst_valid", {31'b0, dmem_req_valid}, 32'd1);
      rst_n        = 1'b0;
      result_src_m = 2'b00;
      reg_write_m  = 1'b0;
      #1;
      checkOutput("mid_rst_valid", {31'b0, dmem_req_valid}, 32'd0);
      checkOutput("mid_rst_stall", {31'b0, stall_m}, 32'd0);
      checkOutput("mid_rst_we", {31'b0, dmem_req_we}, 32'd0);
      checkOutput("mid_rst_addr", dmem_req_addr, 32'd0);
      checkOutput("mid_rst_be", {28'b0, dmem_req_be}, 32'd0);
      checkOutput("mid_rst_wdata", dmem_req_wdata, 32'd0);
      checkOutput("mid_rst_read_data", read_data_m, 32'd0);
      checkOutput("mid_rst_reg_write", {31'b0, reg_write_w_o}, 32'd0);
      checkOutput("mid_rst_bus_err", {31'b0, bus_err}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      modelRd = 32'h0;
      @(negedge clk);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'hFFFFFFFF;
      #3;
      checkOutput("late_rsp_stall", {31'b0, stall_m}, 32'd0);
      checkOutput("late_rsp_valid", {31'b0, dmem_req_valid}, 32'd0);
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      #3;
      checkOutput("late_rsp_read_data", read_data_m, 32'd0);
      checkOutput("late_rsp_bus_err", {31'b0, bus_err}, 32'd0);
      @(negedge clk);
      monEnable = 1'b1;

`ifdef MISALIGN_TRAP_EN
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 0, 1'b1);
`endif

      for (int i = 0; i < 40; i++) begin
         st = 1'($urandom_range(0, 1));
         ld = !st || ($urandom_range(0, 3) == 0);
         if (st) f3 = 3'($urandom_range(0, 2));
         else    f3 = loadF3[$urandom_range(0, 4)];
         rsp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
         applyStimulus(st, ld, f3, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), rsp, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      checkOutput("req_queue_drained", 32'(reqQ.size()), 32'd0);
      checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
